// File: rtl/uart_core_param.sv
// Full-duplex UART core: baud-timed TX/RX state machines, runtime parity,
// and a first-word fall-through receive FIFO with error pulses.
module uart_core_param #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_W       = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              parity_en,
   input  logic              parity_kind,
   input  logic              rxd,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_parity_err,
   output logic              rx_frame_err,
   output logic              rx_overflow
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_W - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);
   localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic kind);
      return (^d) ^ kind;
   endfunction

   logic [2:0]        tx_state;
   logic [CNT_W-1:0]  tx_cnt;
   logic [2:0]        tx_idx;
   logic              tx_sidx;
   logic [DATA_W-1:0] tx_shift;
   logic              tx_par;
   logic              tx_pen;
   logic              tx_tick;
   logic              tx_accept;

   assign tx_ready  = (tx_state == S_IDLE);
   assign tx_busy   = ~tx_ready;
   assign tx_tick   = (tx_cnt == BIT_LAST);
   assign tx_accept = tx_ready & tx_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         txd      <= 1'b1;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_sidx  <= 1'b0;
      end else if (tx_state == S_IDLE) begin
         if (tx_valid) begin
            tx_state <= S_START;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
         end
      end else begin
         tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
         if (tx_tick) begin
            case (tx_state)
               S_START: begin
                  tx_state <= S_DATA;
                  txd      <= tx_shift[0];
               end
               S_DATA: begin
                  if (tx_idx == DATA_LAST) begin
                     tx_sidx  <= 1'b0;
                     tx_state <= tx_pen ? S_PARITY : S_STOP;
                     txd      <= tx_pen ? tx_par : 1'b1;
                  end else begin
                     tx_idx <= tx_idx + 1'b1;
                     txd    <= tx_shift[0];
                  end
               end
               S_PARITY: begin
                  tx_state <= S_STOP;
                  txd      <= 1'b1;
               end
               S_STOP: begin
                  if (tx_sidx == STOP_LAST) tx_state <= S_IDLE;
                  else                      tx_sidx  <= 1'b1;
               end
               default: tx_state <= S_IDLE;
            endcase
         end
      end
   end

   // Frame contents and parity settings are captured once at accept.
   always_ff @(posedge clk) begin
      if (tx_accept) begin
         tx_shift <= tx_data;
         tx_par   <= parity_of(tx_data, parity_kind);
         tx_pen   <= parity_en;
      end else if (tx_tick && (tx_state == S_START || tx_state == S_DATA)) begin
         tx_shift <= tx_shift >> 1;
      end
   end

   logic              rxd_p0, rxd_p1, rxd_p2;
   logic [2:0]        rx_state;
   logic [CNT_W-1:0]  rx_cnt;
   logic [2:0]        rx_idx;
   logic [DATA_W-1:0] rx_shift;
   logic              rx_par, rx_pen, rx_kind;
   logic              rx_tick, rx_half, rx_edge, stop_hit, par_bad;
   logic              push, pop, full;
   logic [AW-1:0]     wptr, rptr;
   logic [AW:0]       count;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   assign rx_tick  = (rx_cnt == BIT_LAST);
   assign rx_half  = (rx_cnt == HALF_LAST);
   assign rx_edge  = rxd_p2 & ~rxd_p1;
   assign stop_hit = (rx_state == S_STOP) & rx_tick;
   assign par_bad  = rx_pen & (rx_par ^ parity_of(rx_shift, rx_kind));
   assign full     = (count == FULL_CNT);
   assign pop      = rx_valid & rx_ready;
   assign push     = stop_hit & rxd_p1 & ~par_bad & (~full | pop);

   // The synchronizer presets high so reset never manufactures a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_p0        <= 1'b1;
         rxd_p1        <= 1'b1;
         rxd_p2        <= 1'b1;
         rx_state      <= S_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overflow   <= 1'b0;
      end else begin
         rxd_p0        <= rxd;
         rxd_p1        <= rxd_p0;
         rxd_p2        <= rxd_p1;
         rx_frame_err  <= stop_hit & ~rxd_p1;
         rx_parity_err <= stop_hit & rxd_p1 & par_bad;
         rx_overflow   <= stop_hit & rxd_p1 & ~par_bad & full & ~pop;
         case (rx_state)
            S_IDLE: begin
               rx_cnt <= '0;
               if (rx_edge) rx_state <= S_START;
            end
            S_START: begin
               if (rx_half) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rxd_p1 ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_DATA, S_PARITY, S_STOP: begin
               rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
               if (rx_tick) begin
                  if (rx_state == S_DATA) begin
                     if (rx_idx == DATA_LAST) rx_state <= rx_pen ? S_PARITY : S_STOP;
                     else                     rx_idx   <= rx_idx + 1'b1;
                  end else if (rx_state == S_PARITY) begin
                     rx_state <= S_STOP;
                  end else begin
                     rx_state <= S_IDLE;
                  end
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_state == S_IDLE && rx_edge) begin
         rx_pen  <= parity_en;
         rx_kind <= parity_kind;
      end
      if (rx_tick && rx_state == S_DATA)   rx_shift <= {rxd_p1, rx_shift[DATA_W-1:1]};
      if (rx_tick && rx_state == S_PARITY) rx_par   <= rxd_p1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= rx_shift;
   end

   assign rx_data  = mem[rptr];
   assign rx_valid = (count != '0);

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: table-driven RX frames against a byte scoreboard,
// plus TX waveform, loopback, overflow, glitch, break and mid-frame reset sequences.
module tb_uart_core_param;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst, parity_en, parity_kind, rxd, rxd_drv, loop_en;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, txd, tx_busy, rx_valid, rx_ready;
   logic       rx_parity_err, rx_frame_err, rx_overflow;

   assign rxd = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_core_param #(
      .CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut (
      .clk(clk), .rst(rst), .parity_en(parity_en), .parity_kind(parity_kind),
      .rxd(rxd), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .txd(txd), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
      .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow)
   );

   int passed = 0;
   int total  = 0;
   int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Scoreboard consumer: every pop must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         perr_cnt += int'(rx_parity_err);
         ferr_cnt += int'(rx_frame_err);
         ovf_cnt  += int'(rx_overflow);
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL rx_pop: got %02h, expected no data", rx_data);
            end else begin
               check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      rxd_drv = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic kind,
                             input logic flip, input logic stopv);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pen) send_bit((^d) ^ kind ^ flip);
      send_bit(stopv);
      rxd_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic wait_tx_idle();
      int n = 0;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("tx_idle_timeout", {31'd0, tx_ready}, 32'd1);
   endtask

   task automatic send_tx(input logic [7:0] d);
      wait_tx_idle();
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       kind;
      logic       flip;
      logic       stopv;
      logic       push;
      int         perr;
      int         ferr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [10:0] frame;
      int          match [11];
      logic        rdy_last;
      int          p0, f0, o0;

      rst = 1'b1; parity_en = 1'b0; parity_kind = 1'b0; rxd_drv = 1'b1;
      loop_en = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;

      vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
      vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
      vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
      vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[6] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
      vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};

      repeat (3) @(negedge clk);
      check("reset_txd",      {31'd0, txd},           32'd1);
      check("reset_tx_ready", {31'd0, tx_ready},      32'd1);
      check("reset_tx_busy",  {31'd0, tx_busy},       32'd0);
      check("reset_rx_valid", {31'd0, rx_valid},      32'd0);
      check("reset_perr",     {31'd0, rx_parity_err}, 32'd0);
      check("reset_ferr",     {31'd0, rx_frame_err},  32'd0);
      check("reset_ovf",      {31'd0, rx_overflow},   32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // TX waveform of 0x55 with even parity; settings changed mid-frame must not matter.
      parity_en = 1'b1; parity_kind = 1'b0; tx_data = 8'h55;
      frame = {1'b1, (^tx_data) ^ parity_kind, tx_data, 1'b0};
      for (int b = 0; b < 11; b++) match[b] = 0;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0; parity_en = 1'b0; parity_kind = 1'b1;
      check("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
      check("tx_busy_set",   {31'd0, tx_busy},  32'd1);
      rdy_last = 1'b1;
      for (int i = 0; i < 11 * CPB; i++) begin
         if (txd === frame[i / CPB]) match[i / CPB]++;
         if (i == 11 * CPB - 1) rdy_last = tx_ready;
         @(negedge clk);
      end
      for (int b = 0; b < 11; b++) check($sformatf("txd_bit%0d_cycles", b), match[b], CPB);
      check("tx_ready_in_last_stop", {31'd0, rdy_last}, 32'd0);
      check("tx_ready_after_stop",   {31'd0, tx_ready}, 32'd1);

      // Table of RX frames against the scoreboard.
      for (int v = 0; v < 8; v++) begin
         p0 = perr_cnt; f0 = ferr_cnt;
         parity_en = vecs[v].pen; parity_kind = vecs[v].kind;
         if (vecs[v].push) exp_q.push_back(vecs[v].data);
         send_frame(vecs[v].data, vecs[v].pen, vecs[v].kind, vecs[v].flip, vecs[v].stopv);
         check($sformatf("vec%0d_perr", v),  perr_cnt - p0, vecs[v].perr);
         check($sformatf("vec%0d_ferr", v),  ferr_cnt - f0, vecs[v].ferr);
         check($sformatf("vec%0d_drain", v), exp_q.size(), 0);
         check($sformatf("vec%0d_empty", v), {31'd0, rx_valid}, 32'd0);
      end

      // Short low glitch on rxd: rejected at the half-bit resample.
      p0 = perr_cnt; f0 = ferr_cnt;
      rxd_drv = 1'b0;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_ferr",     ferr_cnt - f0, 0);
      check("glitch_perr",     perr_cnt - p0, 0);
      check("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);

      // Break: a long low line reports one frame error only.
      parity_en = 1'b0; f0 = ferr_cnt;
      rxd_drv = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("break_ferr_once", ferr_cnt - f0, 1);
      check("break_no_push",   {31'd0, rx_valid}, 32'd0);

      // Loopback 0xA3 with odd parity.
      p0 = perr_cnt; f0 = ferr_cnt;
      loop_en = 1'b1; parity_en = 1'b1; parity_kind = 1'b1;
      exp_q.push_back(8'hA3);
      send_tx(8'hA3);
      wait_tx_idle();
      repeat (2 * CPB) @(negedge clk);
      check("loop_drain", exp_q.size(), 0);
      check("loop_perr",  perr_cnt - p0, 0);
      check("loop_ferr",  ferr_cnt - f0, 0);
      loop_en = 1'b0;

      // Overflow: 17 frames into a 16-deep FIFO with no pops.
      parity_en = 1'b0; rx_ready = 1'b0; o0 = ovf_cnt;
      for (int k = 0; k < 17; k++) begin
         if (k < 16) exp_q.push_back(8'h10 + 8'(k));
         send_frame(8'h10 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("ovf_pulses",   ovf_cnt - o0, 1);
      check("ovf_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("ovf_head",     {24'd0, rx_data}, 32'h10);
      rx_ready = 1'b1;
      repeat (24) @(negedge clk);
      check("ovf_drain",    exp_q.size(), 0);
      check("ovf_empty",    {31'd0, rx_valid}, 32'd0);

      // Reset in the middle of a TX frame, then a clean frame over loopback.
      loop_en = 1'b1; parity_en = 1'b0;
      send_tx(8'hF0);
      repeat (50) @(negedge clk);
      check("midtx_busy", {31'd0, tx_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_txd",      {31'd0, txd},      32'd1);
      check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
      f0 = ferr_cnt; p0 = perr_cnt;
      exp_q.push_back(8'h0F);
      send_tx(8'h0F);
      wait_tx_idle();
      repeat (2 * CPB) @(negedge clk);
      check("post_rst_drain", exp_q.size(), 0);
      check("post_rst_ferr",  ferr_cnt - f0, 0);
      check("post_rst_perr",  perr_cnt - p0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
